// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths and constants for the regfile writeback path.
package regfile_wb_arbiter_pkg;
    localparam int RF_ADDR_W = 5;   // RegAddrBus width
    localparam int RF_DATA_W = 32;  // DataBus width
    localparam logic [RF_DATA_W-1:0] ZERO_WORD = '0;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past last_grant and wraps.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);
    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 1; k <= N; k++) begin
            idx = IW'((int'(last_grant) + k) % N);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port among NREQ writeback sources.
// Optional busy-register scoreboard enabled by REGFILE_SCOREBOARD_EN.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic                   we,
    output logic [ADDR_W-1:0]      waddr,
    output logic [DATA_W-1:0]      wdata
`ifdef REGFILE_SCOREBOARD_EN
    ,
    input  logic                   alloc_valid,
    input  logic [ADDR_W-1:0]      alloc_addr,
    input  logic [ADDR_W-1:0]      busy_raddr1,
    input  logic [ADDR_W-1:0]      busy_raddr2,
    output logic                   busy1,
    output logic                   busy2
`endif
);
    localparam int IW = $clog2(NREQ);

    logic [IW-1:0]     last_grant_q, last_grant_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [NREQ-1:0]   grant;
    logic [IW-1:0]     gidx;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_data;

    rr_arbiter #(.N(NREQ), .IW(IW)) u_rr (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant),
        .grant_idx  (gidx)
    );

    assign g_addr    = req_addr[gidx*ADDR_W +: ADDR_W];
    assign g_data    = req_data[gidx*DATA_W +: DATA_W];
    // ready is forced low during reset so nothing is accepted while the output is being cleared
    assign req_ready = (rst && rdy) ? grant : '0;

    always_comb begin
        last_grant_d = last_grant_q;
        we_d         = we_q;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        if (rdy) begin
            we_d = 1'b0;
            if (|grant) begin
                last_grant_d = gidx;
                we_d         = (g_addr != '0);  // x0 is accepted but never written
                waddr_d      = g_addr;
                wdata_d      = g_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= IW'(NREQ - 1);
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= DATA_W'(ZERO_WORD);
        end else begin
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign we    = we_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;

`ifdef REGFILE_SCOREBOARD_EN
    localparam int NREG = 1 << ADDR_W;

    logic [NREG-1:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        if (rdy) begin
            if (we_q) busy_d[waddr_q] = 1'b0;
            if (alloc_valid && alloc_addr != '0) busy_d[alloc_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy_q <= '0;
        else      busy_q <= busy_d;
    end

    assign busy1 = busy_q[busy_raddr1];
    assign busy2 = busy_q[busy_raddr2];
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: expected outputs queued per cycle, popped after the edge.
module tb_regfile_wb_arbiter;
    localparam int NREQ = 2;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic              clk = 1'b0;
    logic              rst, rdy;
    logic [NREQ-1:0]   req_valid, req_ready;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic              we;
    logic [AW-1:0]     waddr;
    logic [DW-1:0]     wdata;
`ifdef REGFILE_SCOREBOARD_EN
    logic              alloc_valid, busy1, busy2;
    logic [AW-1:0]     alloc_addr, busy_raddr1, busy_raddr2;
    logic [31:0]       m_busy;
`endif

    int n_chk = 0;
    int n_err = 0;
    logic [AW+DW:0] exp_q[$];
    int              m_last;
    logic            m_we;
    logic [AW-1:0]   m_waddr;
    logic [DW-1:0]   m_wdata;
    logic [NREQ-1:0] m_acc;

    regfile_wb_arbiter #(.NREQ(NREQ), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .we(we), .waddr(waddr), .wdata(wdata)
`ifdef REGFILE_SCOREBOARD_EN
        , .alloc_valid(alloc_valid), .alloc_addr(alloc_addr),
        .busy_raddr1(busy_raddr1), .busy_raddr2(busy_raddr2),
        .busy1(busy1), .busy2(busy2)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_last  = NREQ - 1;
        m_we    = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
        m_acc   = '0;
        exp_q.delete();
`ifdef REGFILE_SCOREBOARD_EN
        m_busy = '0;
`endif
    endtask

    // One cycle: inputs already driven; check ready, queue next output, check after the edge.
    task automatic tick();
        int g;
        logic [NREQ-1:0] er;
        logic [AW-1:0] a;
        #1;
        er = '0;
        g  = -1;
        if (rst && rdy)
            for (int k = 1; k <= NREQ; k++) begin
                int i;
                i = (m_last + k) % NREQ;
                if (g < 0 && req_valid[i]) g = i;
            end
        if (g >= 0) er[g] = 1'b1;
        chk("ready", req_ready, er);
`ifdef REGFILE_SCOREBOARD_EN
        chk("busy1", busy1, m_busy[busy_raddr1]);
        chk("busy2", busy2, m_busy[busy_raddr2]);
        if (rdy) begin
            if (m_we) m_busy[m_waddr] = 1'b0;
            if (alloc_valid && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
        end
`endif
        if (rdy) begin
            m_we = 1'b0;
            if (g >= 0) begin
                a       = req_addr[g*AW +: AW];
                m_last  = g;
                m_we    = (a != 0);
                m_waddr = a;
                m_wdata = req_data[g*DW +: DW];
            end
        end
        m_acc = er;
        exp_q.push_back({m_we, m_waddr, m_wdata});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) chk("queue_empty", 0, 1);
        else chk("out", {we, waddr, wdata}, exp_q.pop_front());
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; rdy = 1'b1; req_valid = 2'b11;
        req_addr = '0; req_data = '0;
`ifdef REGFILE_SCOREBOARD_EN
        alloc_valid = 0; alloc_addr = 0; busy_raddr1 = 0; busy_raddr2 = 0;
`endif
        model_reset();
        #1;
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_out", {we, waddr, wdata}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1; req_valid = '0;

        // single write
        req_valid = 2'b01; req_addr[0 +: AW] = 5'd3; req_data[0 +: DW] = 32'hDEADBEEF;
        tick();
        chk("single_we", we, 1);
        chk("single_addr", waddr, 3);
        chk("single_data", wdata, 32'hDEADBEEF);
        req_valid = 2'b00;
        tick();
        chk("single_we_off", we, 0);

        // contention: both valid every cycle
        req_valid = 2'b11;
        req_addr = {5'd2, 5'd1};
        for (int c = 0; c < 4; c++) begin
            req_data = {32'hB000_0000 + c, 32'hA000_0000 + c};
            tick();
            chk("cont_we", we, 1);
            chk("cont_addr", waddr, (c % 2 == 0) ? 2 : 1);
        end

        // x0 write: accepted, not written
        req_valid = 2'b10; req_addr[AW +: AW] = 5'd0; req_data[DW +: DW] = 32'h1234;
        tick();
        chk("x0_we", we, 0);
        req_valid = 2'b11; req_addr = {5'd9, 5'd8};
        #1;
        chk("x0_next_grant", req_ready, 2'b01);
        req_valid = 2'b00;
        tick();

        // rdy stall
        rdy = 1'b0; req_valid = 2'b01; req_addr[0 +: AW] = 5'd4; req_data[0 +: DW] = 32'hCAFE;
        repeat (3) tick();
        rdy = 1'b1;
        tick();
        chk("stall_done", {we, waddr, wdata}, {1'b1, 5'd4, 32'hCAFE});
        req_valid = 2'b00;
        tick();

        // random traffic; addr/data held until accepted
        m_acc = '0;
        for (int c = 0; c < 40; c++) begin
            for (int i = 0; i < NREQ; i++)
                if (!req_valid[i] || m_acc[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    req_addr[i*AW +: AW] = AW'($urandom_range(0, 31));
                    req_data[i*DW +: DW] = $urandom;
                end
            rdy = ($urandom_range(0, 3) != 0);
            tick();
        end
        rdy = 1'b1; req_valid = 2'b00;
        tick();

        // async reset while a write is on the port
        req_valid = 2'b01; req_addr[0 +: AW] = 5'd7; req_data[0 +: DW] = 32'h7777;
        tick();
        chk("pre_rst_we", we, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_we", we, 0);
        chk("async_ready", req_ready, 2'b00);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("async_out", {we, waddr, wdata}, 0);
        rst = 1'b1;
        req_valid = 2'b11; req_addr = {5'd11, 5'd10};
        #1;
        chk("post_rst_first", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        tick();

`ifdef REGFILE_SCOREBOARD_EN
        busy_raddr1 = 5'd5; busy_raddr2 = 5'd0;
        alloc_valid = 1; alloc_addr = 5'd5;
        tick();
        alloc_valid = 0;
        chk("busy_set", busy1, 1);
        req_valid = 2'b01; req_addr[0 +: AW] = 5'd5;
        tick();
        req_valid = 2'b00;
        chk("busy_during_we", busy1, 1);
        tick();
        chk("busy_clear", busy1, 0);
        alloc_valid = 1;
        tick();
        alloc_valid = 0;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00; alloc_valid = 1;
        tick();
        alloc_valid = 0;
        chk("busy_set_wins", busy1, 1);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
